// File: rtl/atm_timeout_ctrl_pkg.sv
// rtl/atm_timeout_ctrl_pkg.sv - shared defaults and state type for the session timeout timer
package atm_timeout_ctrl_pkg;

  localparam int DEF_DIVISOR               = 16;
  localparam int DEF_SLOW_CLK_COUNTER_SIZE = 5;
  localparam int DEF_WAITING_TIMER_SIZE    = 8;
  localparam int DEF_WAITING_TIME          = 5;
  localparam int DEF_WARN_TIME             = 2;
  localparam int DEF_MAX_EXTEND            = 1;

  typedef enum bit [1:0] {
    T_IDLE    = 2'd0,
    T_RUN     = 2'd1,
    T_WARN    = 2'd2,
    T_EXPIRED = 2'd3
  } timer_state_e;

endpackage

// File: rtl/atm_timeout_ctrl_if.sv
// rtl/atm_timeout_ctrl_if.sv - control/status bundle between the main FSM and the timeout timer
interface atm_timeout_ctrl_if #(
  parameter int W = 8
);

  logic         start;
  logic         activity;
  logic         stop;
  logic         extend_req;
  logic [W-1:0] timeout_cfg;
  logic         busy;
  logic         warn;
  logic         timeout;
  logic         slow_tick;
  logic [W-1:0] remaining;
  logic [1:0]   extend_cnt;

  modport master (
    output start, activity, stop, extend_req, timeout_cfg,
    input  busy, warn, timeout, slow_tick, remaining, extend_cnt
  );

  modport slave (
    input  start, activity, stop, extend_req, timeout_cfg,
    output busy, warn, timeout, slow_tick, remaining, extend_cnt
  );

endinterface

// File: rtl/atm_timeout_ctrl_prescaler.sv
// rtl/atm_timeout_ctrl_prescaler.sv - slow-tick prescaler, one tick every DIVISOR enabled cycles
module atm_prescaler #(
  parameter int DIVISOR               = 16,
  parameter int SLOW_CLK_COUNTER_SIZE = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [SLOW_CLK_COUNTER_SIZE-1:0] count;

  assign tick = en && (count == SLOW_CLK_COUNTER_SIZE'(DIVISOR - 1));

  // clr dominates so a reload restarts the full tick period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/atm_timeout_ctrl.sv
// rtl/atm_timeout_ctrl.sv - session inactivity timer with warning, bounded extension and cfg override
module atm_timeout_ctrl
  import atm_timeout_ctrl_pkg::*;
#(
  parameter int DIVISOR               = DEF_DIVISOR,
  parameter int SLOW_CLK_COUNTER_SIZE = DEF_SLOW_CLK_COUNTER_SIZE,
  parameter int WAITING_TIMER_SIZE    = DEF_WAITING_TIMER_SIZE,
  parameter int WAITING_TIME          = DEF_WAITING_TIME,
  parameter int WARN_TIME             = DEF_WARN_TIME,
  parameter int MAX_EXTEND            = DEF_MAX_EXTEND
) (
  input  logic              clk,
  input  logic              rst,
  atm_timeout_ctrl_if.slave bus
);

  localparam int W = WAITING_TIMER_SIZE;

  timer_state_e state, state_nxt;
  logic [W-1:0] limit, limit_nxt;
  logic [W-1:0] remaining_q, remaining_nxt;
  logic [W-1:0] cfg_limit, dec_val;
  logic [1:0]   ext_q, ext_nxt;
  logic         pre_en, pre_clr, tick;
  logic         busy_q, warn_q, timeout_q, slow_tick_q;

  function automatic timer_state_e load_state(input logic [W-1:0] lim);
    return (lim <= W'(WARN_TIME)) ? T_WARN : T_RUN;
  endfunction

  assign cfg_limit = (bus.timeout_cfg == '0) ? W'(WAITING_TIME) : bus.timeout_cfg;
  assign dec_val   = remaining_q - 1'b1;
  assign pre_en    = (state == T_RUN) || (state == T_WARN);

  atm_prescaler #(
    .DIVISOR               (DIVISOR),
    .SLOW_CLK_COUNTER_SIZE (SLOW_CLK_COUNTER_SIZE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= T_IDLE;
      limit       <= '0;
      remaining_q <= '0;
      ext_q       <= '0;
      busy_q      <= 1'b0;
      warn_q      <= 1'b0;
      timeout_q   <= 1'b0;
      slow_tick_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      limit       <= limit_nxt;
      remaining_q <= remaining_nxt;
      ext_q       <= ext_nxt;
      busy_q      <= (state_nxt == T_RUN) || (state_nxt == T_WARN);
      warn_q      <= (state_nxt == T_WARN);
      timeout_q   <= (state_nxt == T_EXPIRED);
      slow_tick_q <= tick;
    end
  end

  // Priority: start > stop > activity > extend_req > tick decrement
  always_comb begin
    state_nxt     = state;
    limit_nxt     = limit;
    remaining_nxt = remaining_q;
    ext_nxt       = ext_q;
    pre_clr       = 1'b0;
    if (bus.start) begin
      limit_nxt     = cfg_limit;
      remaining_nxt = cfg_limit;
      ext_nxt       = '0;
      pre_clr       = 1'b1;
      state_nxt     = load_state(cfg_limit);
    end else begin
      case (state)
        T_RUN, T_WARN: begin
          if (bus.stop) begin
            state_nxt = T_IDLE;
            pre_clr   = 1'b1;
          end else if (bus.activity) begin
            remaining_nxt = limit;
            pre_clr       = 1'b1;
            state_nxt     = load_state(limit);
          end else if (bus.extend_req && (state == T_WARN) && (ext_q < 2'(MAX_EXTEND))) begin
            remaining_nxt = limit;
            ext_nxt       = ext_q + 2'd1;
            pre_clr       = 1'b1;
            state_nxt     = load_state(limit);
          end else if (tick) begin
            if (remaining_q == '0) begin
              state_nxt = T_EXPIRED;
            end else begin
              remaining_nxt = dec_val;
              if (dec_val == '0) begin
                state_nxt = T_EXPIRED;
              end else if (dec_val <= W'(WARN_TIME)) begin
                state_nxt = T_WARN;
              end
            end
          end
        end
        T_EXPIRED: begin
          state_nxt     = T_IDLE;
          remaining_nxt = '0;
        end
        default: begin
          state_nxt = T_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.warn       = warn_q;
  assign bus.timeout    = timeout_q;
  assign bus.slow_tick  = slow_tick_q;
  assign bus.remaining  = remaining_q;
  assign bus.extend_cnt = ext_q;

endmodule

// File: tb/tb_atm_timeout_ctrl.sv
// tb/tb_atm_timeout_ctrl.sv - scoreboard bench for the session timeout timer
module tb_atm_timeout_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  atm_timeout_ctrl_if #(.W(8)) bus ();

  atm_timeout_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [13:0] val;
  } snap_t;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  snap_t snap_q[$];
  ev_t   ev_q[$];
  int    edge_n = 0;
  int    base = 0;
  int    checks = 0;
  int    errors = 0;
  logic  prev_warn = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_event(input int kind);
    ev_t e;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d at edge %0d (relative %0d), none required", kind, edge_n, edge_n - base);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != kind || e.cyc != edge_n) begin
        errors++;
        $display("FAIL event: got kind=%0d at rel edge %0d, required kind=%0d at rel edge %0d",
                 kind, edge_n - base, e.kind, e.cyc - base);
      end
    end
  endtask

  // Monitor: event kind 0 = warn rising, 1 = timeout pulse
  always @(negedge clk) begin
    logic [13:0] act;
    snap_t s;
    ev_t e;
    if (bus.warn && !prev_warn) check_event(0);
    if (bus.timeout) check_event(1);
    prev_warn = bus.warn;
    while (ev_q.size() > 0 && ev_q[0].cyc < edge_n) begin
      e = ev_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event kind=%0d required at rel edge %0d, not seen", e.kind, e.cyc - base);
    end
    if (snap_q.size() > 0 && snap_q[0].cyc <= edge_n) begin
      s = snap_q.pop_front();
      act = {bus.busy, bus.warn, bus.timeout, bus.slow_tick, bus.remaining, bus.extend_cnt};
      checks++;
      if (s.cyc != edge_n || act !== s.val) begin
        errors++;
        $display("FAIL snapshot rel edge %0d: got busy/warn/tmo/tick=%b rem=%0d ext=%0d, required %b rem=%0d ext=%0d",
                 s.cyc - base, act[13:10], act[9:2], act[1:0], s.val[13:10], s.val[9:2], s.val[1:0]);
      end
    end
  end

  task automatic snap(input int e, input logic b, input logic w, input logic t, input logic k,
                      input int rem, input int ext);
    snap_q.push_back('{base + e, {b, w, t, k, 8'(rem), 2'(ext)}});
  endtask

  task automatic ev(input int e, input int kind);
    ev_q.push_back('{base + e, kind});
  endtask

  task automatic begin_start(input logic [7:0] cfg);
    @(negedge clk);
    bus.timeout_cfg = cfg;
    bus.start       = 1'b1;
    base            = edge_n + 1;
  endtask

  task automatic end_start();
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_to(input int e);
    while (edge_n < base + e) @(negedge clk);
  endtask

  // which: 0 activity, 1 stop, 2 extend_req; sampled at rel edge e
  task automatic pulse(input int e, input int which);
    wait_to(e - 1);
    case (which)
      0: bus.activity   = 1'b1;
      1: bus.stop       = 1'b1;
      default: bus.extend_req = 1'b1;
    endcase
    @(negedge clk);
    bus.activity   = 1'b0;
    bus.stop       = 1'b0;
    bus.extend_req = 1'b0;
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.activity    = 1'b0;
    bus.stop        = 1'b0;
    bus.extend_req  = 1'b0;
    bus.timeout_cfg = 8'd0;

    // reset state
    snap(1, 0, 0, 0, 0, 0, 0);
    wait_to(3);
    rst = 1'b1;

    // 1: idle expiry
    begin_start(8'd0);
    snap(0, 1, 0, 0, 0, 5, 0);
    snap(15, 1, 0, 0, 0, 5, 0);
    snap(16, 1, 0, 0, 1, 4, 0);
    snap(48, 1, 1, 0, 1, 2, 0);
    snap(80, 0, 0, 1, 1, 0, 0);
    snap(81, 0, 0, 0, 0, 0, 0);
    ev(48, 0);
    ev(80, 1);
    end_start();
    wait_to(90);

    // 2: activity reload
    begin_start(8'd0);
    snap(40, 1, 0, 0, 0, 5, 0);
    snap(56, 1, 0, 0, 1, 4, 0);
    snap(121, 0, 0, 0, 0, 0, 0);
    ev(88, 0);
    ev(120, 1);
    end_start();
    pulse(40, 0);
    wait_to(125);

    // 3: extension, second request ignored
    begin_start(8'd0);
    snap(50, 1, 0, 0, 0, 5, 1);
    snap(100, 1, 1, 0, 0, 2, 1);
    snap(131, 0, 0, 0, 0, 0, 1);
    ev(48, 0);
    ev(98, 0);
    ev(130, 1);
    end_start();
    pulse(50, 2);
    pulse(100, 2);
    wait_to(135);

    // 4a: stop during WARN
    begin_start(8'd0);
    snap(60, 0, 0, 0, 0, 2, 0);
    snap(61, 0, 0, 0, 0, 2, 0);
    ev(48, 0);
    end_start();
    pulse(60, 1);
    wait_to(100);

    // 4b: activity on the final tick edge wins
    begin_start(8'd0);
    snap(80, 1, 0, 0, 1, 5, 0);
    snap(90, 0, 0, 0, 0, 5, 0);
    ev(48, 0);
    end_start();
    pulse(80, 0);
    pulse(90, 1);
    wait_to(100);

    // 5a: cfg=1 goes straight to WARN
    begin_start(8'd1);
    snap(0, 1, 1, 0, 0, 1, 0);
    snap(16, 0, 0, 1, 1, 0, 0);
    snap(17, 0, 0, 0, 0, 0, 0);
    ev(0, 0);
    ev(16, 1);
    end_start();
    wait_to(20);

    // 5b: cfg=200, later cfg change has no effect
    begin_start(8'd200);
    snap(0, 1, 0, 0, 0, 200, 0);
    snap(16, 1, 0, 0, 1, 199, 0);
    snap(20, 0, 0, 0, 0, 199, 0);
    end_start();
    bus.timeout_cfg = 8'd0;
    pulse(20, 1);
    wait_to(25);

    // 6: async reset mid-RUN, then idle inputs ignored
    begin_start(8'd0);
    snap(29, 1, 0, 0, 0, 4, 0);
    snap(30, 0, 0, 0, 0, 0, 0);
    snap(34, 0, 0, 0, 0, 0, 0);
    snap(50, 0, 0, 0, 0, 0, 0);
    snap(53, 0, 0, 0, 0, 0, 0);
    end_start();
    wait_to(29);
    @(posedge clk);
    #3 rst = 1'b0;
    wait_to(32);
    rst = 1'b1;
    pulse(52, 0);
    wait_to(60);

    checks++;
    if (snap_q.size() != 0 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: %0d snapshots and %0d events unchecked, required 0",
               snap_q.size(), ev_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
